// File: rtl/vsynth_cnt_pkg.sv
// Shared constants for the synth counter blocks.
// Direction encoding used on every dir port.
package vsynth_cnt_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/updn_cnt_mod.sv
// One modulo-MODULO up/down digit with sync clear and clamped load.
// Ports: clk, clr, ce, dir, load, d[W] in; q[W] digit value, tc terminal flag out.
module updn_cnt_mod
  import vsynth_cnt_pkg::*;
#(
  parameter int MODULO = 10,
  parameter int W      = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ce,
  input  logic         dir,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         tc
);

  localparam logic [W-1:0] MAX = W'(MODULO - 1);

  logic [W-1:0] dl;
  logic [W-1:0] q_up;
  logic [W-1:0] q_dn;

  // Out-of-range load values are clamped to the top state.
  assign dl   = (d > MAX) ? MAX : d;
  assign q_up = (q == MAX) ? '0 : q + 1'b1;
  assign q_dn = (q == '0) ? MAX : q - 1'b1;
  assign tc   = (dir == DIR_UP) ? (q == MAX)
                                : (q == '0);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= dl;
    end else if (ce) begin
      q <= (dir == DIR_UP) ? q_up : q_dn;
    end
  end

endmodule

// File: rtl/updn_cnt_chain.sv
// Cascade of DIGITS up/down digits with ripple enable, load and saturate.
// Ports: clk, clr, ce, dir, load, d[DIGITS*W] in; q[DIGITS*W] count, co carry/borrow out.
module updn_cnt_chain
  import vsynth_cnt_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int MODULO = 10,
  parameter int W      = 4,
  parameter bit SAT    = 1'b0
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                ce,
  input  logic                dir,
  input  logic                load,
  input  logic [DIGITS*W-1:0] d,
  output logic [DIGITS*W-1:0] q,
  output logic                co
);

  logic [DIGITS-1:0] tc;
  logic [DIGITS-1:0] en;
  logic [DIGITS:0]   tc_and;
  logic              all_tc;
  logic              hold;

  // tc_and[k] is high when every digit below k is terminal.
  assign tc_and[0] = 1'b1;
  assign all_tc    = tc_and[DIGITS];

  // In saturating mode the full-terminal state freezes the chain.
  assign hold = SAT && all_tc;
  assign co   = ce & ~clr & ~load & all_tc;

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    assign tc_and[k+1] = tc_and[k] & tc[k];
    assign en[k]       = ce & tc_and[k] & ~hold;

    updn_cnt_mod #(
      .MODULO (MODULO),
      .W      (W)
    ) u_dig (
      .clk  (clk),
      .clr  (clr),
      .ce   (en[k]),
      .dir  (dir),
      .load (load),
      .d    (d[k*W +: W]),
      .q    (q[k*W +: W]),
      .tc   (tc[k])
    );
  end

endmodule

// File: tb/tb_updn_cnt_chain.sv
// Directed bench for updn_cnt_chain: wrap, saturate and base-6 chains.
// Three DUTs share the control inputs; each task checks one of them.
module tb_updn_cnt_chain;

  logic       clk = 1'b0;
  logic       clr, ce, dir, load;
  logic [7:0] d2;
  logic [8:0] d3;
  logic [7:0] q_a, q_s;
  logic [8:0] q_m;
  logic       co_a, co_s, co_m;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  updn_cnt_chain #(
    .DIGITS(2), .MODULO(10), .W(4), .SAT(1'b0)
  ) u_a (
    .clk(clk), .clr(clr), .ce(ce), .dir(dir),
    .load(load), .d(d2), .q(q_a), .co(co_a)
  );

  updn_cnt_chain #(
    .DIGITS(2), .MODULO(10), .W(4), .SAT(1'b1)
  ) u_s (
    .clk(clk), .clr(clr), .ce(ce), .dir(dir),
    .load(load), .d(d2), .q(q_s), .co(co_s)
  );

  updn_cnt_chain #(
    .DIGITS(3), .MODULO(6), .W(3), .SAT(1'b0)
  ) u_m (
    .clk(clk), .clr(clr), .ce(ce), .dir(dir),
    .load(load), .d(d3), .q(q_m), .co(co_m)
  );

  function automatic logic [7:0] bcd(input int v);
    bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [8:0] b6(input int v);
    b6 = {3'(v / 36), 3'((v / 6) % 6), 3'(v % 6)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    clr = 1; ce = 1; load = 0; dir = 0;
    d2 = 8'h00; d3 = 9'h000;
    for (int i = 0; i < 3; i++) begin
      settle();
      vecs++;
      if (co_a !== 1'b0) begin
        errs++;
        $display("FAIL rst_co got %b want 0", co_a);
      end
      tick();
      vecs++;
      if (q_a !== 8'h00) begin
        errs++;
        $display("FAIL rst_q got %h want 00", q_a);
      end
    end
    clr = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      vecs++;
      if (q_a !== bcd(i)) begin
        errs++;
        $display("FAIL rst_cnt got %h want %h", q_a, bcd(i));
      end
    end
  endtask

  task automatic test_up_wrap();
    int cos = 0;
    clr = 1; ce = 0; tick();
    clr = 0; ce = 1; dir = 0;
    for (int i = 0; i < 100; i++) begin
      settle();
      if (co_a === 1'b1) cos++;
      vecs++;
      if (co_a !== (i == 99)) begin
        errs++;
        $display("FAIL up_co i=%0d got %b", i, co_a);
      end
      tick();
      vecs++;
      if (q_a !== bcd((i + 1) % 100)) begin
        errs++;
        $display("FAIL up_q got %h want %h",
                 q_a, bcd((i + 1) % 100));
      end
    end
    vecs++;
    if (cos != 1) begin
      errs++;
      $display("FAIL up_co_cnt got %0d want 1", cos);
    end
  endtask

  task automatic test_down();
    int e = 5;
    ce = 0; load = 1; d2 = 8'h05; tick();
    load = 0; ce = 1; dir = 1;
    vecs++;
    if (q_a !== 8'h05) begin
      errs++;
      $display("FAIL dn_load got %h want 05", q_a);
    end
    for (int i = 0; i < 6; i++) begin
      settle();
      vecs++;
      if (co_a !== (e == 0)) begin
        errs++;
        $display("FAIL dn_co e=%0d got %b", e, co_a);
      end
      tick();
      e = (e == 0) ? 99 : e - 1;
      vecs++;
      if (q_a !== bcd(e)) begin
        errs++;
        $display("FAIL dn_q got %h want %h", q_a, bcd(e));
      end
    end
    // Reverse mid-count: 99 -> 00 -> 99 on consecutive edges.
    dir = 0; tick();
    vecs++;
    if (q_a !== 8'h00) begin
      errs++;
      $display("FAIL rev_up got %h want 00", q_a);
    end
    dir = 1; tick();
    vecs++;
    if (q_a !== 8'h99) begin
      errs++;
      $display("FAIL rev_dn got %h want 99", q_a);
    end
  endtask

  task automatic test_load_clamp();
    ce = 1; dir = 0; load = 1; d2 = 8'h3F;
    settle();
    vecs++;
    if (co_a !== 1'b0) begin
      errs++;
      $display("FAIL ld_co got %b want 0", co_a);
    end
    tick();
    vecs++;
    if (q_a !== 8'h39) begin
      errs++;
      $display("FAIL ld_3f got %h want 39", q_a);
    end
    d2 = 8'hAB; tick();
    vecs++;
    if (q_a !== 8'h99) begin
      errs++;
      $display("FAIL ld_ab got %h want 99", q_a);
    end
    // Loading the terminal value with ce set: co still suppressed.
    settle();
    vecs++;
    if (co_a !== 1'b0) begin
      errs++;
      $display("FAIL ld_term_co got %b want 0", co_a);
    end
    load = 0; ce = 0; dir = 1; tick();
    vecs++;
    if (q_a !== 8'h99) begin
      errs++;
      $display("FAIL hold got %h want 99", q_a);
    end
  endtask

  task automatic test_sat();
    ce = 0; load = 1; d2 = 8'h98; tick();
    load = 0; ce = 1; dir = 0;
    settle();
    vecs++;
    if (co_s !== 1'b0) begin
      errs++;
      $display("FAIL sat_co0 got %b want 0", co_s);
    end
    tick();
    vecs++;
    if (q_s !== 8'h99) begin
      errs++;
      $display("FAIL sat_99 got %h want 99", q_s);
    end
    for (int i = 0; i < 3; i++) begin
      settle();
      vecs++;
      if (co_s !== 1'b1) begin
        errs++;
        $display("FAIL sat_co got %b want 1", co_s);
      end
      tick();
      vecs++;
      if (q_s !== 8'h99) begin
        errs++;
        $display("FAIL sat_hold got %h want 99", q_s);
      end
    end
    dir = 1;
    settle();
    vecs++;
    if (co_s !== 1'b0) begin
      errs++;
      $display("FAIL sat_dn_co got %b want 0", co_s);
    end
    tick();
    vecs++;
    if (q_s !== 8'h98) begin
      errs++;
      $display("FAIL sat_dn got %h want 98", q_s);
    end
  endtask

  task automatic test_clr_priority();
    ce = 0; load = 1; d2 = 8'h47; tick();
    clr = 1; load = 1; d2 = 8'h12; ce = 1;
    settle();
    vecs++;
    if (co_a !== 1'b0) begin
      errs++;
      $display("FAIL clrp_co got %b want 0", co_a);
    end
    tick();
    vecs++;
    if (q_a !== 8'h00) begin
      errs++;
      $display("FAIL clrp_q got %h want 00", q_a);
    end
    clr = 0; load = 0;
  endtask

  task automatic test_mod6();
    int cos = 0;
    clr = 1; ce = 0; load = 0; tick();
    clr = 0; ce = 1; dir = 0;
    for (int i = 0; i < 216; i++) begin
      settle();
      if (co_m === 1'b1) cos++;
      vecs++;
      if (co_m !== (i == 215)) begin
        errs++;
        $display("FAIL m6_co i=%0d got %b", i, co_m);
      end
      tick();
      vecs++;
      if (q_m !== b6((i + 1) % 216)) begin
        errs++;
        $display("FAIL m6_q got %h want %h",
                 q_m, b6((i + 1) % 216));
      end
    end
    vecs++;
    if (cos != 1) begin
      errs++;
      $display("FAIL m6_co_cnt got %0d want 1", cos);
    end
    ce = 0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down();
    test_load_clamp();
    test_sat();
    test_clr_priority();
    test_mod6();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
